clkdvd_ratio_detect: RTL and testbench
======================================

// Module: clkdvd_ratio_detect
// PURPOSE
//  Receive-side partner of the clkdvd clock divider. Watches a divided-clock stream
//  (clkdvd out, same clk domain) and recovers the 2-bit divide select x that produced it.
//  Reports the decoded ratio, a lock flag and a fault pulse. Used as the built-in
//  checker on the divider output.
// PARAMETERS
//  LOCK_COUNT  2   consecutive equal legal periods required to lock; >=1
//  TIMEOUT     64  clk cycles without a rising edge before lock is dropped; must be >16
//  CNT_W       8   period counter width; 2**CNT_W > TIMEOUT
// PORTS
//  clk     in   1      system clock, rising edge
//  rst     in   1      synchronous, active-high reset
//  div_in  in   1      divided clock under test; synchronous to clk
//  ratio   out  2      decoded select: 00=/2, 01=/4, 10=/8, 11=/16
//  valid   out  1      high while locked; ratio is trustworthy only when high
//  err     out  1      one-cycle pulse on illegal period or timeout
//  period  out  CNT_W  last measured period in clk cycles
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): ratio=00, valid=0, err=0, period=0, state=IDLE, d_q=0,
//    pcnt=0, match_cnt=0. Reset mid-operation aborts everything; it takes priority.
//  - Edge detect: d_q<=div_in every cycle; rise = div_in & ~d_q. Only rising edges matter;
//    duty cycle is not checked.
//  - pcnt: loads 1 on a rise cycle, else increments, saturating at TIMEOUT.
//    On a rise, measured = pcnt (cycles since the previous rise) and period<=measured.
//  - Legal periods: 2->00, 4->01, 8->10, 16->11. Any other measured value is illegal.
//  - FSM (registered outputs, updated on the cycle after the rise):
//    IDLE: no reference edge. On rise -> ACQ, cand unset, match_cnt=0; no measurement.
//    ACQ : on rise with legal code: if code==cand then match_cnt++, else cand=code and
//          match_cnt=1. When match_cnt reaches LOCK_COUNT: ratio<=cand, valid<=1 -> LOCKED.
//          On rise with illegal period: match_cnt=0, cand unset, err pulse, stay in ACQ.
//    LOCKED: rise with same code: stay. Different legal code: valid<=0, cand=code,
//          match_cnt=1 -> ACQ (no err). Illegal: valid<=0, match_cnt=0, err pulse -> ACQ.
//    Timeout (pcnt==TIMEOUT, no rise) in ACQ or LOCKED: valid<=0, err pulse -> IDLE.
//    Timeout in IDLE: no err, stays in IDLE.
//  - ratio holds its last locked value while valid=0; it updates only on lock.
//  - Simultaneous rise and pcnt==TIMEOUT: the rise wins, and the measurement (=TIMEOUT)
//    is illegal.
//  - Latency: with LOCK_COUNT=N, valid rises 1 cycle after the (N+1)-th rise following
//    IDLE. err is high for exactly one cycle per fault.
// TESTING
//  1. rst 5 cycles, then /4 stream (2 high,2 low), LOCK_COUNT=2 -> valid=1 one cycle after
//     3rd rise, ratio=01, period=4, err never high.
//  2. Locked at /2 (ratio=00), switch to /16 -> valid=0 after first 16-period rise, err=0;
//     valid=1 with ratio=11 after the second one.
//  3. Illegal stream, 3 high/3 low (period 6) -> err pulses 1 cycle per rise, valid stays
//     0, period=6.
//  4. Locked at /8, then div_in held low -> pcnt hits 64: valid=0, err 1-cycle pulse,
//     IDLE; the next rise is reference only (period unchanged until second rise).
//  5. Locked at /16, rst asserted 1 cycle mid-period -> next cycle ratio=00, valid=0,
//     period=0, err=0; relock needs 3 rises.
//  6. Locked at /8 with one injected period of 4 then /8 again -> valid drops (err=0),
//     cand=01; next 8-period rise sets cand=10, match=1; following rise relocks ratio=10.

Source files
------------

// File: rtl/clkdvd_ratio_detect.sv
// Recovers the divide select of a clkdvd stream from its rising-edge spacing.
// ratio/valid/err/period update one cycle after the qualifying rise or timeout.
// No backpressure: div_in is observed every cycle and nothing can stall.
module clkdvd_ratio_detect #(
    parameter int LOCK_COUNT = 2,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic [1:0]       ratio,
    output logic             valid,
    output logic             err,
    output logic [CNT_W-1:0] period
);

    localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_COUNT);
    localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] P2     = CNT_W'(2);
    localparam logic [CNT_W-1:0] P4     = CNT_W'(4);
    localparam logic [CNT_W-1:0] P8     = CNT_W'(8);
    localparam logic [CNT_W-1:0] P16    = CNT_W'(16);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    state_t           state, state_n;
    logic             d_q;
    logic [CNT_W-1:0] pcnt, pcnt_n;
    logic [MW-1:0]    match_cnt, match_n;
    logic [1:0]       cand, cand_n;
    logic             cand_ok, cand_ok_n;
    logic [1:0]       ratio_n;
    logic             valid_n, err_n;
    logic [CNT_W-1:0] period_n;
    logic             rise, timeout, legal;
    logic [1:0]       code;

    assign rise    = div_in & ~d_q;
    assign timeout = (pcnt == TO_V) && !rise;

    always_comb begin
        legal = 1'b1;
        code  = 2'b00;
        case (pcnt)
            P2:      code = 2'b00;
            P4:      code = 2'b01;
            P8:      code = 2'b10;
            P16:     code = 2'b11;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n   = state;
        match_n   = match_cnt;
        cand_n    = cand;
        cand_ok_n = cand_ok;
        ratio_n   = ratio;
        valid_n   = valid;
        err_n     = 1'b0;
        period_n  = period;
        if (rise)
            pcnt_n = CNT_W'(1);
        else if (pcnt == TO_V)
            pcnt_n = pcnt;
        else
            pcnt_n = pcnt + 1'b1;

        case (state)
            IDLE: begin
                // First edge only establishes the timing reference.
                if (rise) begin
                    state_n   = ACQ;
                    cand_ok_n = 1'b0;
                    match_n   = '0;
                end
            end
            ACQ: begin
                if (rise) begin
                    period_n = pcnt;
                    if (legal) begin
                        if (cand_ok && code == cand) begin
                            match_n = match_cnt + 1'b1;
                        end else begin
                            cand_n    = code;
                            cand_ok_n = 1'b1;
                            match_n   = MW'(1);
                        end
                        if (match_n == LOCK_M) begin
                            ratio_n = cand_n;
                            valid_n = 1'b1;
                            state_n = LOCKED;
                        end
                    end else begin
                        match_n   = '0;
                        cand_ok_n = 1'b0;
                        err_n     = 1'b1;
                    end
                end else if (timeout) begin
                    valid_n = 1'b0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            LOCKED: begin
                if (rise) begin
                    period_n = pcnt;
                    if (legal) begin
                        if (code != ratio) begin
                            valid_n   = 1'b0;
                            cand_n    = code;
                            cand_ok_n = 1'b1;
                            match_n   = MW'(1);
                            state_n   = ACQ;
                        end
                    end else begin
                        valid_n   = 1'b0;
                        match_n   = '0;
                        cand_ok_n = 1'b0;
                        err_n     = 1'b1;
                        state_n   = ACQ;
                    end
                end else if (timeout) begin
                    valid_n = 1'b0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            d_q       <= 1'b0;
            pcnt      <= '0;
            match_cnt <= '0;
            cand      <= 2'b00;
            cand_ok   <= 1'b0;
            ratio     <= 2'b00;
            valid     <= 1'b0;
            err       <= 1'b0;
            period    <= '0;
        end else begin
            state     <= state_n;
            d_q       <= div_in;
            pcnt      <= pcnt_n;
            match_cnt <= match_n;
            cand      <= cand_n;
            cand_ok   <= cand_ok_n;
            ratio     <= ratio_n;
            valid     <= valid_n;
            err       <= err_n;
            period    <= period_n;
        end
    end

endmodule

// File: tb/tb_clkdvd_ratio_detect.sv
// Bench for clkdvd_ratio_detect: directed table, corner sequences, random streams vs a timestamp model.
module tb_clkdvd_ratio_detect;

    localparam int LC = 2;
    localparam int TO = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          div_in;
    logic [1:0]    ratio;
    logic          valid;
    logic          err;
    logic [CW-1:0] period;

    clkdvd_ratio_detect #(.LOCK_COUNT(LC), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .div_in(div_in),
        .ratio(ratio), .valid(valid), .err(err), .period(period)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int errs_seen = 0;

    // Reference model: timestamps of rises and the run of equal codes since acquisition began.
    int         cyc = 0;
    bit         m_prev = 1'b0;
    bit         m_ref = 1'b0;
    int         m_last = 0;
    int         run[$];
    logic [1:0] m_ratio = 2'b00;
    bit         m_valid = 1'b0;
    bit         m_err = 1'b0;
    int         m_period = 0;

    typedef struct {
        int         hi;
        int         lo;
        int         reps;
        logic [1:0] ratio;
        logic       valid;
        int         period;
        int         errs;
    } vec_t;

    vec_t tbl[8];

    function automatic int code_of(int m);
        case (m)
            2:       return 0;
            4:       return 1;
            8:       return 2;
            16:      return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit rise;
        int m;
        int c;
        rise  = div_in && !m_prev;
        m_err = 1'b0;
        if (rst) begin
            m_prev = 1'b0; m_ref = 1'b0; run.delete();
            m_ratio = 2'b00; m_valid = 1'b0; m_period = 0;
        end else begin
            if (rise) begin
                if (m_ref) begin
                    m = cyc - m_last;
                    if (m > TO) m = TO;
                    m_period = m;
                    c = code_of(m);
                    if (c < 0) begin
                        m_err = 1'b1; m_valid = 1'b0; run.delete();
                    end else if (m_valid) begin
                        if (c != int'(m_ratio)) begin
                            m_valid = 1'b0; run.delete(); run.push_back(c);
                        end
                    end else begin
                        if (run.size() > 0 && run[$] != c) run.delete();
                        run.push_back(c);
                        if (run.size() >= LC) begin
                            m_valid = 1'b1; m_ratio = 2'(c);
                        end
                    end
                end else begin
                    m_ref = 1'b1; run.delete();
                end
                m_last = cyc;
            end else if (m_ref && (cyc - m_last) >= TO) begin
                m_err = 1'b1; m_valid = 1'b0; m_ref = 1'b0; run.delete();
            end
            m_prev = div_in;
        end
        cyc++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        if (err === 1'b1) errs_seen++;
        check("cycle", {20'd0, ratio, valid, err, period},
              {20'd0, m_ratio, m_valid, m_err, 8'(m_period)});
    endtask

    task automatic cyc_in(bit v);
        div_in = v;
        step();
    endtask

    task automatic period_in(int hi, int lo);
        repeat (hi) cyc_in(1'b1);
        repeat (lo) cyc_in(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; div_in = 1'b0;
        repeat (5) step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int p;
        int hi;
        rst = 1'b1; div_in = 1'b0;

        tbl[0] = '{hi:2, lo:2, reps:3, ratio:2'b01, valid:1'b1, period:4,  errs:0};
        tbl[1] = '{hi:1, lo:1, reps:4, ratio:2'b00, valid:1'b1, period:2,  errs:0};
        tbl[2] = '{hi:4, lo:4, reps:3, ratio:2'b10, valid:1'b1, period:8,  errs:0};
        tbl[3] = '{hi:8, lo:8, reps:3, ratio:2'b11, valid:1'b1, period:16, errs:0};
        tbl[4] = '{hi:3, lo:3, reps:4, ratio:2'b00, valid:1'b0, period:6,  errs:3};
        tbl[5] = '{hi:2, lo:2, reps:2, ratio:2'b00, valid:1'b0, period:4,  errs:0};
        tbl[6] = '{hi:5, lo:5, reps:3, ratio:2'b00, valid:1'b0, period:10, errs:2};
        tbl[7] = '{hi:1, lo:3, reps:3, ratio:2'b01, valid:1'b1, period:4,  errs:0};

        do_reset();
        check("reset_outputs", {ratio, valid, err, period}, 12'h000);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            errs_seen = 0;
            repeat (tbl[i].reps) period_in(tbl[i].hi, tbl[i].lo);
            check($sformatf("tbl%0d_ratio", i), ratio, tbl[i].ratio);
            check($sformatf("tbl%0d_valid", i), valid, tbl[i].valid);
            check($sformatf("tbl%0d_period", i), period, tbl[i].period);
            check($sformatf("tbl%0d_errs", i), errs_seen, tbl[i].errs);
        end

        // Locked at /2, switch to /16.
        do_reset();
        repeat (3) period_in(1, 1);
        check("sw_lock2", {ratio, valid}, {2'b00, 1'b1});
        period_in(8, 8);
        errs_seen = 0;
        cyc_in(1'b1);
        check("sw_drop", {valid, err}, 2'b00);
        check("sw_period", period, 16);
        repeat (7) cyc_in(1'b1);
        repeat (8) cyc_in(1'b0);
        cyc_in(1'b1);
        check("sw_relock", {ratio, valid}, {2'b11, 1'b1});
        check("sw_errs", errs_seen, 0);

        // Locked at /8, then input stalls low until timeout.
        do_reset();
        repeat (3) period_in(4, 4);
        n = 0;
        while (err !== 1'b1 && n < 100) begin
            cyc_in(1'b0);
            n++;
        end
        check("to_cycles", n, 57);
        check("to_valid", valid, 0);
        cyc_in(1'b0);
        check("to_err_width", err, 0);
        cyc_in(1'b1);
        check("to_ref_period", {valid, period}, {1'b0, 8'd8});
        repeat (3) cyc_in(1'b0);
        cyc_in(1'b1);
        check("to_second_period", period, 4);

        // Reset in the middle of a locked /16 period.
        do_reset();
        repeat (3) period_in(8, 8);
        check("rst_pre_lock", {ratio, valid}, {2'b11, 1'b1});
        repeat (5) cyc_in(1'b1);
        rst = 1'b1; div_in = 1'b0;
        step();
        rst = 1'b0;
        check("rst_mid", {ratio, valid, err, period}, 12'h000);
        period_in(8, 8);
        period_in(8, 8);
        check("rst_two_rises", valid, 0);
        cyc_in(1'b1);
        check("rst_relock", {ratio, valid}, {2'b11, 1'b1});

        // Locked at /8 with a single injected /4 period.
        do_reset();
        repeat (3) period_in(4, 4);
        period_in(4, 4);
        period_in(2, 2);
        errs_seen = 0;
        cyc_in(1'b1);
        check("inj_drop", {valid, err, period}, {1'b0, 1'b0, 8'd4});
        repeat (3) cyc_in(1'b1);
        repeat (4) cyc_in(1'b0);
        cyc_in(1'b1);
        check("inj_cand", {valid, period}, {1'b0, 8'd8});
        repeat (3) cyc_in(1'b1);
        repeat (4) cyc_in(1'b0);
        cyc_in(1'b1);
        check("inj_relock", {ratio, valid}, {2'b10, 1'b1});
        check("inj_errs", errs_seen, 0);

        // Rise lands exactly on the timeout count: measured period is TIMEOUT, illegal.
        do_reset();
        repeat (3) period_in(4, 4);
        cyc_in(1'b1);
        repeat (63) cyc_in(1'b0);
        cyc_in(1'b1);
        check("edge_to", {valid, err, period}, {1'b0, 1'b1, 8'd64});
        repeat (3) cyc_in(1'b1);
        repeat (4) cyc_in(1'b0);
        cyc_in(1'b1);
        check("edge_to_next", {valid, err, period}, {1'b0, 1'b0, 8'd8});

        // Random streams against the model.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                div_in = 1'($urandom);
                step();
                rst = 1'b0;
            end
            case ($urandom_range(0, 9))
                0, 1:    p = 2;
                2, 3:    p = 4;
                4, 5:    p = 8;
                6, 7:    p = 16;
                8:       p = $urandom_range(2, 40);
                default: p = $urandom_range(60, 80);
            endcase
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                hi = $urandom_range(1, p - 1);
                period_in(hi, p - hi);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
